sr_latch_driver: RTL and testbench

- Upstream control stage for the gated SR latch; produces its `s`, `r`, `en` and `rst` inputs.
- Takes two raw, asynchronous, possibly bouncing request lines (set and clear).
- Synchronises and debounces them, arbitrates between them, and emits a timed setup/enable/hold sequence.
- Guarantees the latch never sees `s=r=1` or a data change while `en` is high.

---
 rtl/sr_latch_driver.sv | 184 ++++++++++++++++++
 tb/tb_sr_latch_driver.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_latch_driver.sv
// Control stage for a gated SR latch: synchronises and debounces raw set/clear
// requests, arbitrates them and runs a setup/enable/hold sequence. Optional latch
// feedback check is compiled in with SR_FB_CHECK_EN.
module sr_latch_driver #(
  parameter int DB_CYCLES = 4,
  parameter int EN_WIDTH  = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic set_req,
  input  logic clr_req,
`ifdef SR_FB_CHECK_EN
  input  logic q_fb,
  input  logic qb_fb,
  output logic fb_err,
`endif
  output logic s,
  output logic r,
  output logic en,
  output logic latch_rst,
  output logic busy,
  output logic conflict
);

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

  localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);
  localparam logic [3:0] EN_LAST = 4'(EN_WIDTH);

  logic       set_meta, set_sync, clr_meta, clr_sync;
  logic       set_db, clr_db;
  logic [7:0] set_cnt, clr_cnt;
  logic       set_rise, clr_rise;
  logic       set_pend, clr_pend;
  logic       take_set, take_clr;
  logic       rst_tail;

  state_t     state, state_n;
  logic [3:0] en_cnt, en_cnt_n;
  logic       s_n, r_n, en_n, busy_n, conflict_n;

  // A rising debounced edge is recognised in the same cycle the level flips,
  // so the pending flag is ready for IDLE on the very next edge.
  assign set_rise = set_sync && !set_db && (set_cnt == DB_LAST);
  assign clr_rise = clr_sync && !clr_db && (clr_cnt == DB_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      set_meta  <= 1'b0;
      set_sync  <= 1'b0;
      clr_meta  <= 1'b0;
      clr_sync  <= 1'b0;
      set_db    <= 1'b0;
      clr_db    <= 1'b0;
      set_cnt   <= '0;
      clr_cnt   <= '0;
      set_pend  <= 1'b0;
      clr_pend  <= 1'b0;
      latch_rst <= 1'b1;
      rst_tail  <= 1'b1;
    end else begin
      set_meta <= set_req;
      set_sync <= set_meta;
      clr_meta <= clr_req;
      clr_sync <= clr_meta;

      if (set_sync != set_db) begin
        if (set_cnt == DB_LAST) begin
          set_db  <= set_sync;
          set_cnt <= '0;
        end else begin
          set_cnt <= set_cnt + 8'd1;
        end
      end else begin
        set_cnt <= '0;
      end

      if (clr_sync != clr_db) begin
        if (clr_cnt == DB_LAST) begin
          clr_db  <= clr_sync;
          clr_cnt <= '0;
        end else begin
          clr_cnt <= clr_cnt + 8'd1;
        end
      end else begin
        clr_cnt <= '0;
      end

      // Consume first, then record: an event landing on the dispatch cycle survives.
      set_pend <= (set_pend & ~take_set) | set_rise;
      clr_pend <= (clr_pend & ~take_clr) | clr_rise;

      latch_rst <= rst_tail;
      rst_tail  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      en_cnt   <= '0;
      s        <= 1'b0;
      r        <= 1'b0;
      en       <= 1'b0;
      busy     <= 1'b0;
      conflict <= 1'b0;
    end else begin
      state    <= state_n;
      en_cnt   <= en_cnt_n;
      s        <= s_n;
      r        <= r_n;
      en       <= en_n;
      busy     <= busy_n;
      conflict <= conflict_n;
    end
  end

  // Outputs are computed for the state being entered and registered with it.
  always_comb begin
    state_n    = state;
    en_cnt_n   = en_cnt;
    s_n        = s;
    r_n        = r;
    en_n       = 1'b0;
    busy_n     = busy;
    conflict_n = 1'b0;
    take_set   = 1'b0;
    take_clr   = 1'b0;
    case (state)
      IDLE: begin
        s_n    = 1'b0;
        r_n    = 1'b0;
        busy_n = 1'b0;
        if (clr_pend) begin
          r_n        = 1'b1;
          busy_n     = 1'b1;
          conflict_n = set_pend;
          take_set   = 1'b1;
          take_clr   = 1'b1;
          state_n    = SETUP;
        end else if (set_pend) begin
          s_n      = 1'b1;
          busy_n   = 1'b1;
          take_set = 1'b1;
          state_n  = SETUP;
        end
      end
      SETUP: begin
        busy_n   = 1'b1;
        en_n     = 1'b1;
        en_cnt_n = 4'd1;
        state_n  = PULSE;
      end
      PULSE: begin
        busy_n = 1'b1;
        if (en_cnt == EN_LAST) begin
          state_n = HOLD;
        end else begin
          en_n     = 1'b1;
          en_cnt_n = en_cnt + 4'd1;
        end
      end
      HOLD: begin
        s_n     = 1'b0;
        r_n     = 1'b0;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef SR_FB_CHECK_EN
  // s still carries the commanded value during HOLD (1 = set, 0 = clear).
  always_ff @(posedge clk) begin
    if (!rst) begin
      fb_err <= 1'b0;
    end else begin
      fb_err <= (state == HOLD) && ((q_fb != s) || (q_fb == qb_fb));
    end
  end
`endif

endmodule

// File: tb/tb_sr_latch_driver.sv
// Bench for sr_latch_driver: directed vector table, then randomized requests
// against a timeline-level reference model.
module tb_sr_latch_driver;

  localparam int DB = 4;
  localparam int EW = 2;

  logic clk;
  logic rst, set_req, clr_req;
  logic s, r, en, latch_rst, busy, conflict;
`ifdef SR_FB_CHECK_EN
  logic q_fb, qb_fb, fb_err;
`endif

  sr_latch_driver #(.DB_CYCLES(DB), .EN_WIDTH(EW)) dut (
    .clk(clk),
    .rst(rst),
    .set_req(set_req),
    .clr_req(clr_req),
`ifdef SR_FB_CHECK_EN
    .q_fb(q_fb),
    .qb_fb(qb_fb),
    .fb_err(fb_err),
`endif
    .s(s),
    .r(r),
    .en(en),
    .latch_rst(latch_rst),
    .busy(busy),
    .conflict(conflict)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_set_h[$], m_clr_h[$];
  bit m_set_v[$], m_clr_v[$];
  bit m_db_s, m_db_c, m_pend_s, m_pend_c;
  int m_t;
  bit m_cmd_set, m_conf, m_lr, m_lr_next;

  // Level flips once DB consecutive samples since the last flip/reset disagree with it.
  function automatic bit window_flip(input bit q[$], input bit lvl);
    if (q.size() < DB) return 1'b0;
    foreach (q[i]) if (q[i] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge(input logic rst_i, input logic set_i, input logic clr_i);
    bit vis_s, vis_c, rise_s, rise_c, cons_s, cons_c;
    if (!rst_i) begin
      m_set_h = '{1'b0, 1'b0};
      m_clr_h = '{1'b0, 1'b0};
      m_set_v.delete();
      m_clr_v.delete();
      m_db_s = 0; m_db_c = 0; m_pend_s = 0; m_pend_c = 0;
      m_t = 0; m_cmd_set = 0; m_conf = 0;
      m_lr = 1; m_lr_next = 1;
    end else begin
      vis_s = m_set_h[m_set_h.size()-2];
      vis_c = m_clr_h[m_clr_h.size()-2];
      m_set_h.push_back(set_i);
      m_clr_h.push_back(clr_i);
      if (m_set_h.size() > 4) void'(m_set_h.pop_front());
      if (m_clr_h.size() > 4) void'(m_clr_h.pop_front());

      rise_s = 0; rise_c = 0;
      m_set_v.push_back(vis_s);
      if (m_set_v.size() > DB) void'(m_set_v.pop_front());
      if (window_flip(m_set_v, m_db_s)) begin
        m_db_s = ~m_db_s; rise_s = m_db_s; m_set_v.delete();
      end
      m_clr_v.push_back(vis_c);
      if (m_clr_v.size() > DB) void'(m_clr_v.pop_front());
      if (window_flip(m_clr_v, m_db_c)) begin
        m_db_c = ~m_db_c; rise_c = m_db_c; m_clr_v.delete();
      end

      // m_t: 0 idle, 1 setup, 2..EW+1 enable, EW+2 hold
      m_conf = 0; cons_s = 0; cons_c = 0;
      if (m_t == 0) begin
        if (m_pend_c) begin
          m_cmd_set = 0; m_conf = m_pend_s; cons_s = 1; cons_c = 1; m_t = 1;
        end else if (m_pend_s) begin
          m_cmd_set = 1; cons_s = 1; m_t = 1;
        end
      end else if (m_t == EW + 2) begin
        m_t = 0;
      end else begin
        m_t++;
      end
      m_pend_s = (m_pend_s & !cons_s) | rise_s;
      m_pend_c = (m_pend_c & !cons_c) | rise_c;
      m_lr = m_lr_next;
      m_lr_next = 0;
    end
  endtask

  // ---------------- driver ----------------
  task automatic tick(input logic rst_i, input logic set_i, input logic clr_i);
    rst = rst_i; set_req = set_i; clr_req = clr_i;
    @(posedge clk);
    #1;
    model_edge(rst_i, set_i, clr_i);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic rst_i, set_i, clr_i;
    logic es, er, een, ebusy, econf, elr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rs, input logic st, input logic cl,
                     input logic es, input logic er, input logic een,
                     input logic eb, input logic ec, input logic el, input int n);
    vec_t v;
    v = '{rst_i: rs, set_i: st, clr_i: cl, es: es, er: er, een: een,
          ebusy: eb, econf: ec, elr: el};
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  logic prev_s, prev_r, prev_en;
  int   set_left, clr_left;
  logic set_v, clr_v, rst_v;

  initial begin
    rst = 1'b0; set_req = 1'b0; clr_req = 1'b0;
`ifdef SR_FB_CHECK_EN
    q_fb = 1'b0; qb_fb = 1'b1;
`endif

    //   rst set clr | s r en busy conf lr | count
    // reset for 3 cycles, latch_rst one extra cycle
    add(0, 0, 0,  0, 0, 0, 0, 0, 1,  3);
    add(1, 0, 0,  0, 0, 0, 0, 0, 1,  1);
    add(1, 0, 0,  0, 0, 0, 0, 0, 0,  3);
    // clean set: s at edge 6, en edges 7-8, hold edge 9, idle edge 10
    add(1, 1, 0,  0, 0, 0, 0, 0, 0,  6);
    add(1, 1, 0,  1, 0, 0, 1, 0, 0,  1);
    add(1, 1, 0,  1, 0, 1, 1, 0, 0,  EW);
    add(1, 1, 0,  1, 0, 0, 1, 0, 0,  1);
    add(1, 1, 0,  0, 0, 0, 0, 0, 0,  2);
    add(1, 0, 0,  0, 0, 0, 0, 0, 0,  10);
    // bounce: 3 high, 1 low, 3 high, low
    add(1, 1, 0,  0, 0, 0, 0, 0, 0,  3);
    add(1, 0, 0,  0, 0, 0, 0, 0, 0,  1);
    add(1, 1, 0,  0, 0, 0, 0, 0, 0,  3);
    add(1, 0, 0,  0, 0, 0, 0, 0, 0,  12);
    // simultaneous rise: clear wins, conflict once, no set afterwards
    add(1, 1, 1,  0, 0, 0, 0, 0, 0,  6);
    add(1, 1, 1,  0, 1, 0, 1, 1, 0,  1);
    add(1, 1, 1,  0, 1, 1, 1, 0, 0,  EW);
    add(1, 1, 1,  0, 1, 0, 1, 0, 0,  1);
    add(1, 1, 1,  0, 0, 0, 0, 0, 0,  8);
    add(1, 0, 0,  0, 0, 0, 0, 0, 0,  10);
    // queued clear debounces during the set pulse
    add(1, 1, 0,  0, 0, 0, 0, 0, 0,  3);
    add(1, 1, 1,  0, 0, 0, 0, 0, 0,  3);
    add(1, 1, 1,  1, 0, 0, 1, 0, 0,  1);
    add(1, 1, 1,  1, 0, 1, 1, 0, 0,  EW);
    add(1, 1, 1,  1, 0, 0, 1, 0, 0,  1);
    add(1, 1, 1,  0, 0, 0, 0, 0, 0,  1);
    add(1, 1, 1,  0, 1, 0, 1, 0, 0,  1);
    add(1, 1, 1,  0, 1, 1, 1, 0, 0,  EW);
    add(1, 1, 1,  0, 1, 0, 1, 0, 0,  1);
    add(1, 1, 1,  0, 0, 0, 0, 0, 0,  4);
    add(1, 0, 0,  0, 0, 0, 0, 0, 0,  10);
    // reset while en=1, nothing resumes
    add(1, 1, 0,  0, 0, 0, 0, 0, 0,  6);
    add(1, 1, 0,  1, 0, 0, 1, 0, 0,  1);
    add(1, 1, 0,  1, 0, 1, 1, 0, 0,  1);
    add(0, 0, 0,  0, 0, 0, 0, 0, 1,  1);
    add(1, 0, 0,  0, 0, 0, 0, 0, 1,  1);
    add(1, 0, 0,  0, 0, 0, 0, 0, 0,  15);

    foreach (vecs[i]) begin
      tick(vecs[i].rst_i, vecs[i].set_i, vecs[i].clr_i);
      chk($sformatf("vec%0d_s", i),        s,         vecs[i].es);
      chk($sformatf("vec%0d_r", i),        r,         vecs[i].er);
      chk($sformatf("vec%0d_en", i),       en,        vecs[i].een);
      chk($sformatf("vec%0d_busy", i),     busy,      vecs[i].ebusy);
      chk($sformatf("vec%0d_conflict", i), conflict,  vecs[i].econf);
      chk($sformatf("vec%0d_latch_rst", i), latch_rst, vecs[i].elr);
    end

    // randomized requests against the model
    tick(0, 0, 0);
    tick(0, 0, 0);
    prev_s = s; prev_r = r; prev_en = en;
    set_left = 0; clr_left = 0; set_v = 0; clr_v = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (set_left == 0) begin
        set_v = 1'($urandom_range(0, 1)); set_left = $urandom_range(1, 14);
      end
      if (clr_left == 0) begin
        clr_v = 1'($urandom_range(0, 1)); clr_left = $urandom_range(1, 14);
      end
      set_left--; clr_left--;
      rst_v = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      tick(rst_v, set_v, clr_v);
      chk($sformatf("rnd%0d_s", cyc),        s,         (m_t != 0) &&  m_cmd_set);
      chk($sformatf("rnd%0d_r", cyc),        r,         (m_t != 0) && !m_cmd_set);
      chk($sformatf("rnd%0d_en", cyc),       en,        (m_t >= 2) && (m_t <= EW + 1));
      chk($sformatf("rnd%0d_busy", cyc),     busy,      m_t != 0);
      chk($sformatf("rnd%0d_conflict", cyc), conflict,  m_conf);
      chk($sformatf("rnd%0d_latch_rst", cyc), latch_rst, m_lr);
      chk($sformatf("rnd%0d_s_and_r", cyc),  s & r,     1'b0);
      if (prev_en === 1'b1 && rst_v) begin
        chk($sformatf("rnd%0d_sr_stable", cyc), (s !== prev_s) || (r !== prev_r), 1'b0);
      end
      prev_s = s; prev_r = r; prev_en = en;
    end

`ifdef SR_FB_CHECK_EN
    // latch feedback stuck at 0 during a set: fb_err pulses after HOLD
    tick(0, 0, 0);
    tick(0, 0, 0);
    for (int i = 0; i < 4; i++) tick(1, 0, 0);
    q_fb = 1'b0; qb_fb = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      tick(1, 1, 0);
      chk($sformatf("fb%0d_fb_err", k), fb_err, (k == 10) ? 1'b1 : 1'b0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
